// File: rtl/ld_scalar_mult.sv
// Left-to-right double-and-add controller for an external Lopez-Dahab point ALU.
// Optional macro LD_CONST_TIME_EN: visit ADD for every scalar bit (dummy adds) for fixed latency.
module ld_scalar_mult #(
    parameter int KW = 4,
    parameter int FW = 4,
    localparam int PW = 3 * FW
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [PW-1:0] P,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] result,
    output logic          alu_op,
    output logic [PW-1:0] alu_A,
    output logic [PW-1:0] alu_B,
    input  logic [PW-1:0] alu_R
);

    localparam int IW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [PW-1:0] INF = PW'(1);
`ifdef LD_CONST_TIME_EN
    localparam logic CONST_TIME = 1'b1;
`else
    localparam logic CONST_TIME = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] q_r, q_s;
    logic          q_inf_r, q_inf_s;
    logic [IW-1:0] idx_r, idx_s;
    logic [KW-1:0] k_r;
    logic [PW-1:0] p_r;
    logic [PW-1:0] result_r;
    logic          done_r;
    logic          busy_r;
    logic          load_s;
    logic          bit_s;
    logic          alu_op_s;
    logic [PW-1:0] alu_a_s;
    logic [PW-1:0] alu_b_s;

    // Next-state, accumulator update and ALU drive
    always_comb begin
        state_s  = state_r;
        q_s      = q_r;
        q_inf_s  = q_inf_r;
        idx_s    = idx_r;
        load_s   = 1'b0;
        alu_op_s = 1'b0;
        alu_a_s  = '0;
        alu_b_s  = '0;
        bit_s    = k_r[idx_r];
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    q_s     = INF;
                    q_inf_s = 1'b1;
                    idx_s   = IW'(KW - 1);
                    state_s = DBL;
                end else begin
                    state_s = IDLE;
                end
            end
            DBL: begin
                if (!q_inf_r) begin
                    alu_op_s = 1'b1;
                    alu_a_s  = q_r;
                    q_s      = alu_R;
                end else begin
                    q_s = q_r;
                end
                if (CONST_TIME || bit_s) begin
                    state_s = ADD;
                end else if (idx_r == '0) begin
                    state_s = DONE;
                end else begin
                    idx_s   = idx_r - IW'(1);
                    state_s = DBL;
                end
            end
            ADD: begin
                if (!bit_s) begin
                    // Dummy add: ALU exercised like a real add, result discarded
                    alu_op_s = 1'b0;
                    alu_a_s  = p_r;
                    alu_b_s  = q_inf_r ? p_r : q_r;
                end else if (q_inf_r) begin
                    q_s     = p_r;
                    q_inf_s = 1'b0;
                end else if (q_r == p_r) begin
                    alu_op_s = 1'b1;
                    alu_a_s  = q_r;
                    q_s      = alu_R;
                end else begin
                    alu_op_s = 1'b0;
                    alu_a_s  = p_r;
                    alu_b_s  = q_r;
                    q_s      = alu_R;
                end
                if (idx_r == '0) begin
                    state_s = DONE;
                end else begin
                    idx_s   = idx_r - IW'(1);
                    state_s = DBL;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand capture and registered status/result
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r  <= IDLE;
            q_r      <= INF;
            q_inf_r  <= 1'b1;
            idx_r    <= '0;
            k_r      <= '0;
            p_r      <= '0;
            result_r <= INF;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            q_inf_r <= q_inf_s;
            idx_r   <= idx_s;
            if (load_s) begin
                k_r <= k;
                p_r <= P;
            end else begin
                k_r <= k_r;
                p_r <= p_r;
            end
            if (state_s == DONE) begin
                result_r <= q_s;
            end else begin
                result_r <= result_r;
            end
            done_r <= (state_s == DONE);
            busy_r <= (state_s != IDLE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign alu_op = alu_op_s;
    assign alu_A  = alu_a_s;
    assign alu_B  = alu_b_s;

endmodule
